// File: rtl/heartbeat_monitor.sv
`default_nettype none
// ============================================================================
// Module   : heartbeat_monitor
// Purpose  : Qualifies the PWM heartbeat from one CPU and produces the
//            per-CPU health flag (io) consumed by the switchover core.
//            Every rising edge of the synchronized pin yields one period
//            and high-time measurement. A LOST/ACQUIRE/LOCKED state machine
//            asserts io only after LOCK_CNT consecutive good measurements.
//            It drops io after LOSS_CNT consecutive bad measurements or when
//            a pulse is missing (timeout).
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            pwm        - raw heartbeat pin, asynchronous to clk
//            io         - registered health flag, 1 = CPU alive and in spec
//            meas_valid - one-cycle strobe; period_q/high_q/meas_good updated
//            period_q   - last measured period (clk cycles)
//            high_q     - last measured high time (clk cycles)
//            meas_good  - last measurement inside both windows
//            fault      - last fault: 00 none, 01 timeout,
//                         10 period out of range, 11 high time out of range
//            stats_clr  - (optional) synchronous clear of err_count
//            err_count  - (optional) saturating count of bad measurements
//                         and timeouts
// Options  : HEARTBEAT_MONITOR_STATS_EN - adds stats_clr / err_count
// Revision : 1.0 - initial release
// ============================================================================
module heartbeat_monitor #(
   parameter int CNT_W      = 17,
   parameter int PERIOD_MIN = 36000,
   parameter int PERIOD_MAX = 44000,
   parameter int HIGH_MIN   = 16000,
   parameter int HIGH_MAX   = 24000,
   parameter int LOCK_CNT   = 4,
   parameter int LOSS_CNT   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm,
`ifdef HEARTBEAT_MONITOR_STATS_EN
   input  logic             stats_clr,
   output logic [15:0]      err_count,
`endif
   output logic             io,
   output logic             meas_valid,
   output logic [CNT_W-1:0] period_q,
   output logic [CNT_W-1:0] high_q,
   output logic             meas_good,
   output logic [1:0]       fault
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(LOSS_CNT + 1);

   localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(PERIOD_MIN);
   localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(PERIOD_MAX);
   localparam logic [CNT_W-1:0] H_MIN   = CNT_W'(HIGH_MIN);
   localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(HIGH_MAX);
   localparam logic [CNT_W-1:0] T_LIM   = CNT_W'(PERIOD_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_TOP = '1;
   localparam logic [GW-1:0]    LOCK_C  = GW'(LOCK_CNT);
   localparam logic [BW-1:0]    LOSS_C  = BW'(LOSS_CNT);

   localparam logic [1:0] ST_LOST    = 2'd0;
   localparam logic [1:0] ST_ACQUIRE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   localparam logic [1:0] F_NONE    = 2'b00;
   localparam logic [1:0] F_TIMEOUT = 2'b01;
   localparam logic [1:0] F_PERIOD  = 2'b10;
   localparam logic [1:0] F_HIGH    = 2'b11;

   // ---------------------------------------------------------------------
   // Input path: two synchronizer flops plus an edge-detect history flop
   // ---------------------------------------------------------------------
   logic s1, s2, s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= pwm;
         s2 <= s1;
         s3 <= s2;
      end
   end

   logic rise;
   assign rise = s2 & ~s3;

   // ---------------------------------------------------------------------
   // Period and high-time counters. Both restart at 1 on the edge cycle so
   // that the value present on the next edge equals the true cycle count.
   // ---------------------------------------------------------------------
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt <= '0;
         high_cnt   <= '0;
      end else begin
         if (rise)
            period_cnt <= CNT_W'(1);
         else if (period_cnt != CNT_TOP)
            period_cnt <= period_cnt + 1'b1;

         if (rise)
            high_cnt <= CNT_W'(1);
         else if (s2 && (high_cnt != CNT_TOP))
            high_cnt <= high_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Measurement classification
   // ---------------------------------------------------------------------
   logic       armed;
   logic       per_ok, high_ok, good;
   logic       do_meas, timeout;
   logic [1:0] bad_code;

   assign per_ok   = (period_cnt >= P_MIN) && (period_cnt <= P_MAX);
   assign high_ok  = (high_cnt >= H_MIN) && (high_cnt <= H_MAX);
   assign good     = per_ok & high_ok;
   // Period violations take precedence over high-time violations
   assign bad_code = per_ok ? F_HIGH : F_PERIOD;
   assign do_meas  = rise & armed;
   // Counter passes PERIOD_MAX+1 exactly once per missing edge; a rise in
   // that same cycle would have period_cnt==PERIOD_MAX+1 as a measurement.
   assign timeout  = armed & ~rise & (period_cnt == T_LIM);

   // ---------------------------------------------------------------------
   // Lock / loss state machine
   // ---------------------------------------------------------------------
   logic [1:0]    state, state_nx;
   logic          armed_nx;
   logic [GW-1:0] good_cnt, good_nx, good_inc;
   logic [BW-1:0] bad_cnt, bad_nx, bad_inc;
   logic [1:0]    fault_nx;

   assign good_inc = good_cnt + 1'b1;
   assign bad_inc  = bad_cnt + 1'b1;

   always_comb begin
      state_nx = state;
      armed_nx = armed;
      good_nx  = good_cnt;
      bad_nx   = bad_cnt;
      fault_nx = fault;
      if (timeout) begin
         state_nx = ST_LOST;
         armed_nx = 1'b0;
         good_nx  = '0;
         bad_nx   = '0;
         fault_nx = F_TIMEOUT;
      end else if (rise) begin
         if (!armed) begin
            // First edge after loss or reset only starts a measurement
            armed_nx = 1'b1;
            state_nx = ST_ACQUIRE;
            good_nx  = '0;
            bad_nx   = '0;
         end else if (state == ST_ACQUIRE) begin
            if (good) begin
               if (good_inc == LOCK_C) begin
                  state_nx = ST_LOCKED;
                  good_nx  = '0;
                  bad_nx   = '0;
                  fault_nx = F_NONE;
               end else begin
                  good_nx = good_inc;
               end
            end else begin
               good_nx  = '0;
               fault_nx = bad_code;
            end
         end else if (state == ST_LOCKED) begin
            if (good) begin
               bad_nx = '0;
            end else begin
               fault_nx = bad_code;
               if (bad_inc == LOSS_C) begin
                  state_nx = ST_ACQUIRE;
                  good_nx  = '0;
                  bad_nx   = '0;
               end else begin
                  bad_nx = bad_inc;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_LOST;
         armed      <= 1'b0;
         good_cnt   <= '0;
         bad_cnt    <= '0;
         fault      <= F_NONE;
         io         <= 1'b0;
         meas_valid <= 1'b0;
         period_q   <= '0;
         high_q     <= '0;
         meas_good  <= 1'b0;
      end else begin
         state      <= state_nx;
         armed      <= armed_nx;
         good_cnt   <= good_nx;
         bad_cnt    <= bad_nx;
         fault      <= fault_nx;
         io         <= (state_nx == ST_LOCKED);
         meas_valid <= do_meas;
         if (do_meas) begin
            period_q  <= period_cnt;
            high_q    <= high_cnt;
            meas_good <= good;
         end
      end
   end

`ifdef HEARTBEAT_MONITOR_STATS_EN
   // ---------------------------------------------------------------------
   // Error statistics: clear has priority over a same-cycle increment
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count <= '0;
      else if (stats_clr)
         err_count <= '0;
      else if (((do_meas & ~good) | timeout) && (err_count != 16'hFFFF))
         err_count <= err_count + 16'd1;
   end
`endif

endmodule
`default_nettype wire
